// File: rtl/kernel_pkg.sv
// kernel_pkg: kernel-fetch sizing constants, FSM state and coefficient word type
package kernel_pkg;
    localparam int DATA_W      = 24;
    localparam int ADDR_W      = 24;
    localparam int KERNEL_SIZE = 9;
    localparam int NUM_KERNELS = 3;
    typedef logic [DATA_W-1:0] kword_t;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} kf_state_e;
endpackage

// File: rtl/kernel_fetch.sv
// kernel_fetch: reads one kernel word-by-word from data memory and holds it under valid/ready
module kernel_fetch #(
    parameter int DATA_W      = kernel_pkg::DATA_W,
    parameter int ADDR_W      = kernel_pkg::ADDR_W,
    parameter int KERNEL_SIZE = kernel_pkg::KERNEL_SIZE,
    parameter int NUM_KERNELS = kernel_pkg::NUM_KERNELS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    kernel_sel,
    output logic [ADDR_W-1:0]             mem_a,
    output logic                          mem_we,
    input  logic [DATA_W-1:0]             mem_rd,
    output logic [KERNEL_SIZE*DATA_W-1:0] kernel_out,
    output logic                          valid,
    input  logic                          ready,
    output logic                          busy,
    output logic                          sel_err
);
    import kernel_pkg::*;
    localparam int IDX_W = $clog2(KERNEL_SIZE);
    kf_state_e                     state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [ADDR_W-1:0]             base_q, base_d;
    logic [KERNEL_SIZE*DATA_W-1:0] kernel_q, kernel_d;
    logic                          sel_ok, take, accept, last;
    assign sel_ok = int'(kernel_sel) < NUM_KERNELS;
    assign take   = (state_q == IDLE) || (state_q == HOLD && ready);
    assign accept = start && sel_ok && take;
    assign last   = idx_q == IDX_W'(KERNEL_SIZE - 1);
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // Next state: an accepted start always wins, including back-to-back from HOLD
    always_comb begin
        state_d = accept                         ? FETCH :
                  (state_q == FETCH && last)     ? HOLD  :
                  (state_q == HOLD && ready)     ? IDLE  : state_q;
    end
    // Outputs: address only driven while fetching, kernel register exported as-is
    always_comb begin
        busy    = state_q == FETCH;
        valid   = state_q == HOLD;
        mem_a   = (state_q == FETCH) ? base_q + ADDR_W'(idx_q) : '0;
        sel_err = start && !sel_ok && take;
    end
    assign mem_we     = 1'b0;
    assign kernel_out = kernel_q;
    // Datapath next state: latch base on accept, capture one word per FETCH cycle
    always_comb begin
        idx_d    = idx_q;
        base_d   = base_q;
        kernel_d = kernel_q;
        if (accept) begin
            idx_d  = '0;
            base_d = ADDR_W'(kernel_sel) * ADDR_W'(KERNEL_SIZE);
        end else if (state_q == FETCH) begin
            kernel_d[DATA_W*int'(idx_q) +: DATA_W] = mem_rd;
            idx_d = last ? '0 : idx_q + IDX_W'(1);
        end
    end
    // Datapath registers; reset discards any partially fetched kernel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            base_q   <= '0;
            kernel_q <= '0;
        end else begin
            idx_q    <= idx_d;
            base_q   <= base_d;
            kernel_q <= kernel_d;
        end
    end
endmodule

// File: tb/tb_kernel_fetch.sv
// tb_kernel_fetch: directed table, corner sequences and random traffic against a reference model
module tb_kernel_fetch;
    localparam int KW = 24 * 9;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic          ready = 1'b0;
    logic [23:0]   mem_a;
    logic          mem_we;
    logic [23:0]   mem_rd;
    logic [KW-1:0] kernel_out;
    logic          valid, busy, sel_err;
    int            checks = 0;
    int            errors = 0;
    logic [23:0]   mem [27];
    logic [23:0]   pre [27] = '{
        24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h000005, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0,
        24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000009, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
        24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};

    always #5 clk = ~clk;
    assign mem_rd = (mem_a < 24'd27) ? mem[mem_a[4:0]] : 24'hBAD0BA;

    kernel_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kernel_sel(sel),
        .mem_a(mem_a), .mem_we(mem_we), .mem_rd(mem_rd), .kernel_out(kernel_out),
        .valid(valid), .ready(ready), .busy(busy), .sel_err(sel_err));

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] expk(input logic [23:0] c, input logic [23:0] o, input logic [23:0] e);
        logic [KW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[24*i +: 24] = (i == 4) ? c : ((i % 2) != 0 ? o : e);
        return r;
    endfunction

    // Reference model: a fetch is a countdown of words left, a held kernel is a flag
    int            fl = 0;
    bit            hold = 1'b0;
    int            base = 0;
    logic [23:0]   ek [9];
    logic [KW-1:0] ekp;
    logic          m_take, m_acc;
    assign m_take = (fl == 0) && (!hold || ready);
    assign m_acc  = start && (sel < 2'd3) && m_take;
    always_comb begin
        ekp = '0;
        for (int k = 0; k < 9; k++) ekp[24*k +: 24] = ek[k];
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl   <= 0;
            hold <= 1'b0;
            base <= 0;
            for (int k = 0; k < 9; k++) ek[k] <= 24'h0;
        end else if (fl > 0) begin
            ek[9-fl] <= mem[base+9-fl];
            fl       <= fl - 1;
            if (fl == 1) hold <= 1'b1;
        end else if (m_acc) begin
            fl   <= 9;
            base <= int'(sel) * 9;
            hold <= 1'b0;
        end else if (hold && ready) begin
            hold <= 1'b0;
        end
    end
    always @(negedge clk) begin
        chk("model_mem_a", mem_a, (fl > 0) ? 24'(base + 9 - fl) : 24'd0);
        chk("model_busy", busy, fl > 0);
        chk("model_valid", valid, hold);
        chk("model_sel_err", sel_err, start && (sel == 2'd3) && m_take);
        chk("model_mem_we", mem_we, 1'b0);
        chk("model_kernel", kernel_out, ekp);
    end

    typedef struct {
        logic [1:0]  sel;
        int          hold;
        bit          err;
        logic [23:0] c, o, e;
    } vec_t;
    vec_t          tbl[4];
    logic [KW-1:0] prevk = '0;

    task automatic run_txn(input vec_t v);
        logic [KW-1:0] kv;
        kv = v.err ? prevk : expk(v.c, v.o, v.e);
        start = 1'b1; sel = v.sel; ready = 1'b0;
        @(negedge clk);
        chk("txn_sel_err", sel_err, v.err);
        chk("txn_idle_busy", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        if (v.err) begin
            repeat (3) begin
                @(negedge clk);
                chk("err_busy", busy, 1'b0);
                chk("err_mem_a", mem_a, 24'd0);
                chk("err_sel_err_once", sel_err, 1'b0);
                chk("err_kernel_kept", kernel_out, kv);
                @(posedge clk); #1;
            end
            return;
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("fetch_mem_a", mem_a, 24'(int'(v.sel) * 9 + i));
            chk("fetch_busy", busy, 1'b1);
            chk("fetch_valid", valid, 1'b0);
            @(posedge clk); #1;
        end
        for (int d = 0; d < v.hold; d++) begin
            @(negedge clk);
            chk("hold_valid", valid, 1'b1);
            chk("hold_busy", busy, 1'b0);
            chk("hold_mem_a", mem_a, 24'd0);
            chk("hold_kernel", kernel_out, kv);
            @(posedge clk); #1;
        end
        ready = 1'b1;
        @(negedge clk);
        chk("done_valid", valid, 1'b1);
        chk("done_kernel", kernel_out, kv);
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        chk("back_idle_valid", valid, 1'b0);
        chk("back_idle_busy", busy, 1'b0);
        @(posedge clk); #1;
        prevk = kv;
    endtask

    initial begin
        tbl[0] = '{2'd0, 0, 1'b0, 24'h000005, 24'hFFFFFF, 24'h000000};
        tbl[1] = '{2'd1, 5, 1'b0, 24'h000009, 24'hFFFFFF, 24'hFFFFFF};
        tbl[2] = '{2'd3, 0, 1'b1, 24'h0, 24'h0, 24'h0};
        tbl[3] = '{2'd2, 2, 1'b0, 24'h000000, 24'h000000, 24'h000000};
        for (int i = 0; i < 27; i++) mem[i] = pre[i];
        #3;
        chk("rst_mem_a", mem_a, 24'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_kernel", kernel_out, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        foreach (tbl[i]) run_txn(tbl[i]);
        // back-to-back: new start accepted in the same cycle the held kernel is taken
        start = 1'b1; sel = 2'd0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; sel = 2'd2;
        @(negedge clk);
        chk("b2b_valid", valid, 1'b1);
        chk("b2b_first_kernel", kernel_out, expk(24'h5, 24'hFFFFFF, 24'h0));
        @(posedge clk); #1;
        start = 1'b0; ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("b2b_mem_a", mem_a, 24'(18 + i));
            chk("b2b_busy", busy, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b2b_second_kernel", kernel_out, '0);
        chk("b2b_second_valid", valid, 1'b1);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        // reset during the 4th fetch cycle of kernel 1
        start = 1'b1; sel = 2'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("mid_mem_a", mem_a, 24'd12);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_a", mem_a, 24'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_kernel", kernel_out, '0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_rst_valid", valid, 1'b0);
        end
        @(posedge clk); #1;
        // start pulsed mid-fetch with another selector is ignored
        start = 1'b1; sel = 2'd0;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            start = (i == 3); sel = (i == 3) ? 2'd2 : 2'd0;
            @(negedge clk);
            chk("ign_mem_a", mem_a, 24'(i));
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        chk("ign_kernel", kernel_out, expk(24'h5, 24'hFFFFFF, 24'h0));
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        @(posedge clk); #1;
        // random traffic with random memory contents
        for (int i = 0; i < 27; i++) mem[i] = 24'($urandom);
        repeat (3000) begin
            start = ($urandom_range(0, 3) == 0);
            sel   = 2'($urandom_range(0, 3));
            ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_fetch.md
# kernel_fetch

Sequential loader that reads one 3x3 convolution kernel (nine 24-bit words) out of the data memory and presents it, fully assembled, to the convolution datapath. Sits directly upstream of the data memory read port and downstream of the control unit's kernel-select command. It replaces ad-hoc combinational indexing into the kernel area with a start/valid/ready handshake, so the consumer sees a stable kernel for as long as it needs.

## Interface
Parameters:
- DATA_W, 24, word width of data memory and kernel coefficients
- ADDR_W, 24, data memory address width
- KERNEL_SIZE, 9, words per kernel
- NUM_KERNELS, 3, kernels stored back-to-back from address 0

Ports:
- clk  in  1  single system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request to fetch a kernel; sampled only when accepted (see Operation)
- kernel_sel  in  2  kernel index, 0..NUM_KERNELS-1
- mem_a  out  ADDR_W  data memory word address
- mem_we  out  1  data memory write enable, constant 0
- mem_rd  in  DATA_W  data memory read data, combinational from mem_a
- kernel_out  out  KERNEL_SIZE*DATA_W  word i at bits [DATA_W*i+DATA_W-1 : DATA_W*i]
- valid  out  1  kernel_out holds a complete kernel
- ready  in  1  consumer accepts kernel_out
- busy  out  1  fetch in progress
- sel_err  out  1  one-cycle pulse: start with kernel_sel >= NUM_KERNELS

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: mem_a = 0, busy = 0, valid = 0. On start with legal kernel_sel: latch base = kernel_sel*KERNEL_SIZE, idx = 0, go FETCH. On start with illegal kernel_sel: sel_err = 1 for one cycle, stay IDLE, kernel_out unchanged.
- FETCH: mem_a = base + idx (zero-extended to ADDR_W, no wrap). Each rising edge captures mem_rd into word idx, idx increments. Edge capturing idx = KERNEL_SIZE-1 moves to HOLD. busy = 1. start ignored.
- HOLD: valid = 1, kernel_out stable, mem_a = 0. On valid && ready: if start with legal kernel_sel same cycle, go FETCH directly (back-to-back); else go IDLE. start without ready is ignored.
- mem_we is never asserted; block is read-only.
- Words of kernel_out not yet overwritten keep previous values during FETCH; consumer must only use them while valid = 1.

## Timing
- Reset (async assert, any state): state IDLE, idx 0, kernel_out all 0, valid 0, busy 0, sel_err 0, mem_a 0, mem_we 0. Release synchronous to clk.
- Latency: start accepted at edge E0 → valid high after edge E0+KERNEL_SIZE (9 cycles).
- Throughput, ready tied high with start held: one kernel per KERNEL_SIZE+1 cycles.
- mem_a changes only after rising edges; data memory writes on negedge never occur from this block.
- Reset mid-FETCH: partial kernel discarded (cleared), no valid produced.
- kernel_sel sampled only at the accepting edge; later changes have no effect on the fetch in progress.

## Structure
- Shared package kernel_pkg: state enum (IDLE, FETCH, HOLD), constants DATA_W, KERNEL_SIZE, NUM_KERNELS, kernel word typedef. The convolution datapath imports the same package.
- Single module; the index counter and nine-word capture register are inline. No sub-module needed.

## Test plan
Bench memory preload: kernel 0 = 0,FFFFFF,0,FFFFFF,000005,FFFFFF,0,FFFFFF,0; kernel 1 = FFFFFF×4,000009,FFFFFF×4; kernel 2 = all 0.
- start, sel=0, ready=1 → mem_a steps 0..8, valid high 9 cycles after accept, kernel_out word4 = 000005, words 1,3,5,7 = FFFFFF, others 0.
- start, sel=1, ready low 5 cycles after valid → valid and kernel_out (word4 = 000009, rest FFFFFF) stable all 5 cycles, busy 0, return to IDLE one edge after ready.
- start, sel=3 → sel_err pulses one cycle, busy stays 0, no mem_a activity, kernel_out unchanged.
- HOLD with ready=1 and start sel=2 same cycle → direct FETCH at mem_a 18..26, next kernel_out all 0, no IDLE cycle.
- rst_n low at 4th FETCH cycle of sel=1 → all outputs 0 immediately; after release, valid stays 0 until a new start.
- start pulsed during FETCH with different sel → ignored; delivered kernel matches original sel.
